// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: MEM/WB operand forwarding,
// immediate/shamt operand selection, load-use bubble insertion, hold and flush.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm32,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_alu_op,
  input  logic          id_sign,
  input  logic          id_src_imm,
  input  logic          id_src_shamt,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          ex_hold,
  input  logic          ex_flush,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [4:0]    alu_op,
  output logic          alu_sign,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_stall
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [4:0]    op;
    logic          sign;
    logic          src_imm;
    logic          src_shamt;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } ex_reg_t;

  ex_reg_t q, d, id_in;
  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    id_in           = '0;
    id_in.valid     = id_valid;
    id_in.rs_addr   = id_rs_addr;
    id_in.rt_addr   = id_rt_addr;
    id_in.rd_addr   = id_rd_addr;
    id_in.rs        = id_rs_data;
    id_in.rt        = id_rt_data;
    id_in.imm       = id_imm32;
    id_in.shamt     = id_shamt;
    id_in.op        = id_alu_op;
    id_in.sign      = id_sign;
    id_in.src_imm   = id_src_imm;
    id_in.src_shamt = id_src_shamt;
    id_in.reg_write = id_reg_write;
    id_in.mem_read  = id_mem_read;
    id_in.mem_write = id_mem_write;
  end

  // MEM is the younger result, so it wins over WB; $0 is hardwired and never forwarded.
  always_comb begin
    fwd_rs = q.rs;
    if (mem_reg_write && mem_rd_addr == q.rs_addr && q.rs_addr != '0)
      fwd_rs = mem_fwd_data;
    else if (wb_reg_write && wb_rd_addr == q.rs_addr && q.rs_addr != '0)
      fwd_rs = wb_wr_data;
  end

  always_comb begin
    fwd_rt = q.rt;
    if (mem_reg_write && mem_rd_addr == q.rt_addr && q.rt_addr != '0)
      fwd_rt = mem_fwd_data;
    else if (wb_reg_write && wb_rd_addr == q.rt_addr && q.rt_addr != '0)
      fwd_rt = wb_wr_data;
  end

  // rt is a real source unless replaced by the immediate; stores always read rt.
  assign load_use_stall = !ex_hold && !ex_flush && q.valid && q.mem_read &&
                          q.rd_addr != '0 && id_valid &&
                          (q.rd_addr == id_rs_addr ||
                           (q.rd_addr == id_rt_addr && (!id_src_imm || id_mem_write)));

  always_comb begin
    d = q;
    if (ex_flush) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
    end else if (ex_hold) begin
      // Keep forwarded operands so a producer retiring during the hold isn't lost.
      d.rs = fwd_rs;
      d.rt = fwd_rt;
    end else if (load_use_stall) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
    end else begin
      d = id_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign alu_in1       = q.src_shamt ? {{(DW-5){1'b0}}, q.shamt} : fwd_rs;
  assign alu_in2       = q.src_imm ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = q.op;
  assign alu_sign      = q.sign;
  assign ex_valid      = q.valid;
  assign ex_rd_addr    = q.rd_addr;
  assign ex_reg_write  = q.valid && q.reg_write && q.rd_addr != '0;
  assign ex_mem_read   = q.valid && q.mem_read;
  assign ex_mem_write  = q.valid && q.mem_write;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the MIPS-style 5-stage pipeline, directly upstream of the EX-stage ALU.
- Latches the decoded instruction and applies MEM/WB forwarding to the operands.
- Selects the immediate or shift-amount source, then drives the ALU's two operands, 5-bit opcode and signed-compare flag.
- Detects load-use hazards and inserts bubbles. Honours external hold and flush.

Parameters:
- DW, 32, datapath width. Only 32 is supported.
- RW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr / id_rt_addr / id_rd_addr  in  RW each  source and destination register numbers
- id_rs_data / id_rt_data  in  DW each  register-file read data
- id_imm32  in  DW  extended immediate
- id_shamt  in  5  instruction shift amount
- id_alu_op  in  5  ALU opcode; passed through unmodified
- id_sign  in  1  signed compare for slt
- id_src_imm  in  1  operand 2 = imm
- id_src_shamt  in  1  operand 1 = zero-extended shamt
- id_reg_write / id_mem_read / id_mem_write  in  1 each  control
- ex_hold  in  1  freeze this stage
- ex_flush  in  1  squash this stage
- mem_reg_write  in  1  MEM-stage forwarding source: write enable
- mem_rd_addr  in  RW  MEM-stage forwarding source: destination register
- mem_fwd_data  in  DW  MEM-stage forwarding source: data
- wb_reg_write  in  1  WB-stage forwarding source: write enable
- wb_rd_addr  in  RW  WB-stage forwarding source: destination register
- wb_wr_data  in  DW  WB-stage forwarding source: data
- alu_in1 / alu_in2  out  DW each  ALU operands
- alu_op  out  5  ALU opcode
- alu_sign  out  1  signed-compare flag
- ex_valid  out  1  EX-stage instruction valid
- ex_rd_addr  out  RW  EX-stage destination register
- ex_reg_write / ex_mem_read / ex_mem_write  out  1 each  control, gated by ex_valid
- ex_store_data  out  DW  forwarded rt value, used as store data
- load_use_stall  out  1  upstream must hold IF/ID this cycle

Behaviour:
- Reset (async, rst_n=0):
  - all registered fields clear to 0, so ex_valid=0 and all control outputs are 0;
  - alu_in1=alu_in2=0, alu_op=0 (AND), alu_sign=0, load_use_stall=0.
  - Reset asserted mid-stall discards the held instruction.
- Update priority at each rising edge, highest first:
  1. ex_flush: valid and all controls cleared (bubble); data fields don't care.
  2. ex_hold: contents retained, except the rs/rt data registers re-capture their forwarded values (fwd_rs/fwd_rt). A MEM/WB result consumed during the hold is therefore not lost when that stage retires.
  3. load_use_stall: bubble inserted (valid=0); the ID instruction is not captured.
  4. otherwise: all id_* fields captured; ex_valid <= id_valid.
- Forwarding (combinational, from the registered addresses):
  - fwd_rs = MEM data if mem_reg_write and mem_rd_addr==rs_q and rs_q!=0;
  - else WB data if the same conditions hold for WB;
  - else rs_q.
  - fwd_rt is computed the same way from rt_q.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand select:
  - alu_in1 = src_shamt_q ? {27'b0, shamt_q} : fwd_rs.
  - alu_in2 = src_imm_q ? imm_q : fwd_rt.
  - ex_store_data = fwd_rt always.
  - Shifts follow the ALU convention: amount on in1[4:0], value on in2.
- Pass-through and gating:
  - alu_op and alu_sign are passed through registered.
  - ex_reg_write, ex_mem_read and ex_mem_write are registered values ANDed with ex_valid.
  - ex_reg_write is also forced to 0 when ex_rd_addr==0.
- load_use_stall (combinational) asserts when all of the following hold:
  - ex_valid, ex_mem_read and ex_rd_addr!=0;
  - id_valid;
  - ex_rd_addr equals id_rs_addr, or equals id_rt_addr while id_src_imm==0 or id_mem_write==1.
- load_use_stall is suppressed while ex_hold or ex_flush is asserted (those take precedence).
- Latency: an ID instruction appears on the ALU ports 1 cycle after capture. Forwarding adds no cycles.

Test Plan:
- Reset: rst_n=0 mid-stream -> all outputs 0 immediately (no clock edge needed); ex_valid stays 0 until the first valid capture after release.
- Plain capture: add, rs=0x00000005, rt=0x00000003, src_imm=0 -> next cycle alu_in1=5, alu_in2=3, alu_op=00010, ex_valid=1.
- Forward priority: EX rs=$8; MEM writes $8=0xAAAA0000 and WB writes $8=0x11110000 in the same cycle -> alu_in1=0xAAAA0000. Same setup with rs=$0 -> alu_in1=the registered value, no forwarding.
- Shift: sll, shamt=4, rt=0x0000000F, src_shamt=1 -> alu_in1=0x00000004, alu_in2=0x0000000F.
- Load-use: lw $9 in EX, add $10,$9,$1 in ID ->
  - load_use_stall=1 for exactly 1 cycle and a bubble (ex_valid=0) enters EX;
  - the add enters EX next and takes 0x00001234 from WB forwarding.
- Hold/flush:
  - ex_hold for 3 cycles while WB forwards 0xDEADBEEF to rt, WB then retires -> alu_in2 stays 0xDEADBEEF.
  - ex_flush together with ex_hold -> ex_valid=0 next cycle.
